// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared status, icode and register constants
package y86_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;

  // Contents of W when a nop bubble is inserted (also the reset value).
  function automatic w_reg_t w_bubble_val();
    w_reg_t w;
    w.stat  = STAT_AOK;
    w.icode = I_NOP;
    w.val_e = '0;
    w.val_m = '0;
    w.dst_e = REG_NONE;
    w.dst_m = REG_NONE;
    return w;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - M-register inputs, forwarding outputs and W-register fields of the memory stage
interface memory_stage_if;

  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        W_stall;
  logic        W_bubble;

  logic [63:0] m_valM;
  logic [2:0]  m_stat;

  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;

  modport master (
    output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
    output W_stall, W_bubble,
    input  m_valM, m_stat,
    input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
  );

  modport slave (
    input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
    input  W_stall, W_bubble,
    output m_valM, m_stat,
    output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
  );

endinterface

// File: rtl/memory_stage_data_memory.sv
// rtl/memory_stage_data_memory.sv - byte-addressed data memory, 8-byte LE access; MEM_ALIGN_CHECK_EN adds alignment errors
module data_memory #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              access,
  input  logic              we,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata,
  output logic              err
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 8);

  logic [7:0]    mem [MEM_BYTES];
  logic          out_of_range;
  logic          misaligned;
  logic [AW-1:0] base;

  // Full-width unsigned compare: huge addresses never alias into the array.
  assign out_of_range = addr > LAST_ADDR;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = addr[2:0] != 3'b000;
`else
  assign misaligned = 1'b0;
`endif

  assign err = access && (out_of_range || misaligned);

  // Clamp the index when out of range so the 8-byte window stays inside the array.
  assign base = out_of_range ? '0 : addr[AW-1:0];

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[base + AW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86-64 memory stage: access decode, forwarding outputs and W pipeline register
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic         clk,
  input  logic         rst,
  memory_stage_if.slave bus
);

  logic              mem_read;
  logic              mem_write;
  logic              access;
  logic [ADDR_W-1:0] addr;
  logic              dmem_error;
  logic              we;
  logic [63:0]       rdata;
  w_reg_t            w_q;
  w_reg_t            w_next;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = bus.M_valE;
    unique case (bus.M_icode)
      I_MRMOVQ:               mem_read  = 1'b1;
      I_POPQ, I_RET: begin
        mem_read = 1'b1;
        addr     = bus.M_valA;
      end
      I_RMMOVQ, I_PUSHQ, I_CALL: mem_write = 1'b1;
      default: ;
    endcase
  end

  assign access = mem_read || mem_write;

  // Faulting or stalled instructions must not disturb architectural memory.
  assign we = mem_write && !dmem_error && (bus.M_stat == STAT_AOK)
              && !bus.W_stall && !rst;

  data_memory #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_dmem (
    .clk    (clk),
    .addr   (addr),
    .access (access),
    .we     (we),
    .wdata  (bus.M_valA),
    .rdata  (rdata),
    .err    (dmem_error)
  );

  assign bus.m_stat = dmem_error ? STAT_ADR : bus.M_stat;
  assign bus.m_valM = (mem_read && !dmem_error) ? rdata : 64'd0;

  always_comb begin
    w_next.stat  = bus.m_stat;
    w_next.icode = bus.M_icode;
    w_next.val_e = bus.M_valE;
    w_next.val_m = bus.m_valM;
    w_next.dst_e = bus.M_dstE;
    w_next.dst_m = bus.M_dstM;
  end

  // Stall outranks bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q <= w_bubble_val();
    end else if (bus.W_stall) begin
      w_q <= w_q;
    end else if (bus.W_bubble) begin
      w_q <= w_bubble_val();
    end else begin
      w_q <= w_next;
    end
  end

  assign bus.W_stat  = w_q.stat;
  assign bus.W_icode = w_q.icode;
  assign bus.W_valE  = w_q.val_e;
  assign bus.W_valM  = w_q.val_m;
  assign bus.W_dstE  = w_q.dst_e;
  assign bus.W_dstM  = w_q.dst_m;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage
module tb_memory_stage;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  memory_stage_if bus ();

  memory_stage #(
    .MEM_BYTES (1024),
    .ADDR_W    (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] icode, input logic [2:0] stat,
                       input logic [63:0] val_e, input logic [63:0] val_a,
                       input logic [3:0] dst_e, input logic [3:0] dst_m);
    bus.M_icode = icode;
    bus.M_stat  = stat;
    bus.M_cnd   = 1'b0;
    bus.M_valE  = val_e;
    bus.M_valA  = val_a;
    bus.M_dstE  = dst_e;
    bus.M_dstM  = dst_m;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if (bus.W_stat !== 3'd1 || bus.W_icode !== 4'h1) begin
      fails++;
      $display("FAIL reset_stat_icode got %0d/%h exp 1/1", bus.W_stat, bus.W_icode);
    end
    tests++;
    if (bus.W_dstE !== 4'hF || bus.W_dstM !== 4'hF || bus.W_valE !== 64'd0 || bus.W_valM !== 64'd0) begin
      fails++;
      $display("FAIL reset_fields got dstE=%h dstM=%h valE=%h valM=%h exp F F 0 0",
               bus.W_dstE, bus.W_dstM, bus.W_valE, bus.W_valM);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    drive(4'h4, 3'd1, 64'h100, 64'h1122334455667788, 4'hF, 4'hF);
    step();
    tests++;
    if (bus.W_icode !== 4'h4 || bus.W_valE !== 64'h100) begin
      fails++;
      $display("FAIL store_w got icode=%h valE=%h exp 4 100", bus.W_icode, bus.W_valE);
    end
    drive(4'h4, 3'd1, 64'h108, 64'h0, 4'hF, 4'hF);
    step();
    drive(4'h5, 3'd1, 64'h100, 64'h0, 4'hF, 4'h3);
    tests++;
    if (bus.m_valM !== 64'h1122334455667788 || bus.m_stat !== 3'd1) begin
      fails++;
      $display("FAIL load_comb got %h stat %0d exp 1122334455667788 stat 1", bus.m_valM, bus.m_stat);
    end
    tests++;
    if (bus.m_valM[7:0] !== 8'h88) begin
      fails++;
      $display("FAIL load_byte0 got %h exp 88", bus.m_valM[7:0]);
    end
    step();
    tests++;
    if (bus.W_valM !== 64'h1122334455667788 || bus.W_dstM !== 4'h3 || bus.W_icode !== 4'h5) begin
      fails++;
      $display("FAIL load_w got valM=%h dstM=%h icode=%h exp 1122334455667788 3 5",
               bus.W_valM, bus.W_dstM, bus.W_icode);
    end
    drive(4'h5, 3'd1, 64'h101, 64'h0, 4'hF, 4'h3);
    tests++;
    if (bus.m_valM !== 64'h0011223344556677) begin
      fails++;
      $display("FAIL load_unaligned got %h exp 0011223344556677", bus.m_valM);
    end
    // popq reads through valA, not valE.
    drive(4'hB, 3'd1, 64'h3F0, 64'h100, 4'h4, 4'h2);
    tests++;
    if (bus.m_valM !== 64'h1122334455667788) begin
      fails++;
      $display("FAIL popq_addr got %h exp 1122334455667788", bus.m_valM);
    end
    // Non-AOK status must not write.
    drive(4'h4, 3'd2, 64'h100, 64'h0, 4'hF, 4'hF);
    step();
    drive(4'h5, 3'd1, 64'h100, 64'h0, 4'hF, 4'h3);
    tests++;
    if (bus.m_valM !== 64'h1122334455667788) begin
      fails++;
      $display("FAIL hlt_no_write got %h exp 1122334455667788", bus.m_valM);
    end
  endtask

  task automatic test_range();
    drive(4'h5, 3'd1, 64'd1016, 64'h0, 4'hF, 4'h3);
    tests++;
    if (bus.m_stat !== 3'd1) begin
      fails++;
      $display("FAIL range_last_ok got stat %0d exp 1", bus.m_stat);
    end
    drive(4'h5, 3'd1, 64'd1017, 64'h0, 4'hF, 4'h3);
    tests++;
    if (bus.m_stat !== 3'd3 || bus.m_valM !== 64'd0) begin
      fails++;
      $display("FAIL range_1017 got stat %0d valM %h exp 3 0", bus.m_stat, bus.m_valM);
    end
    step();
    tests++;
    if (bus.W_stat !== 3'd3) begin
      fails++;
      $display("FAIL range_w_stat got %0d exp 3", bus.W_stat);
    end
    drive(4'h5, 3'd1, 64'hFFFFFFFFFFFFFFF8, 64'h0, 4'hF, 4'h3);
    tests++;
    if (bus.m_stat !== 3'd3 || bus.m_valM !== 64'd0) begin
      fails++;
      $display("FAIL range_wrap got stat %0d valM %h exp 3 0", bus.m_stat, bus.m_valM);
    end
    drive(4'h1, 3'd1, 64'hFFFFFFFFFFFFFFF8, 64'h0, 4'hF, 4'hF);
    tests++;
    if (bus.m_stat !== 3'd1) begin
      fails++;
      $display("FAIL range_no_access got stat %0d exp 1", bus.m_stat);
    end
  endtask

  task automatic test_stall();
    drive(4'h4, 3'd1, 64'h200, 64'h0, 4'hF, 4'hF);
    step();
    bus.W_stall = 1'b1;
    drive(4'hA, 3'd1, 64'h200, 64'hDEADBEEF, 4'h4, 4'hF);
    step();
    tests++;
    if (bus.W_icode !== 4'h4 || bus.W_valE !== 64'h200 || bus.W_dstE !== 4'hF) begin
      fails++;
      $display("FAIL stall_hold got icode=%h valE=%h dstE=%h exp 4 200 F",
               bus.W_icode, bus.W_valE, bus.W_dstE);
    end
    bus.W_stall = 1'b0;
    drive(4'h5, 3'd1, 64'h200, 64'h0, 4'hF, 4'h1);
    tests++;
    if (bus.m_valM !== 64'd0) begin
      fails++;
      $display("FAIL stall_no_write got %h exp 0", bus.m_valM);
    end
    drive(4'hA, 3'd1, 64'h200, 64'hDEADBEEF, 4'h4, 4'hF);
    step();
    tests++;
    if (bus.W_icode !== 4'hA || bus.W_dstE !== 4'h4) begin
      fails++;
      $display("FAIL push_w got icode=%h dstE=%h exp A 4", bus.W_icode, bus.W_dstE);
    end
    drive(4'h5, 3'd1, 64'h200, 64'h0, 4'hF, 4'h1);
    tests++;
    if (bus.m_valM !== 64'hDEADBEEF) begin
      fails++;
      $display("FAIL push_write got %h exp 00000000deadbeef", bus.m_valM);
    end
  endtask

  task automatic test_stall_bubble();
    drive(4'h5, 3'd1, 64'h200, 64'h0, 4'hF, 4'h6);
    step();
    bus.W_stall  = 1'b1;
    bus.W_bubble = 1'b1;
    drive(4'h4, 3'd1, 64'h300, 64'h5, 4'hF, 4'hF);
    step();
    tests++;
    if (bus.W_icode !== 4'h5 || bus.W_valM !== 64'hDEADBEEF || bus.W_dstM !== 4'h6) begin
      fails++;
      $display("FAIL stall_over_bubble got icode=%h valM=%h dstM=%h exp 5 deadbeef 6",
               bus.W_icode, bus.W_valM, bus.W_dstM);
    end
    bus.W_stall = 1'b0;
    step();
    tests++;
    if (bus.W_icode !== 4'h1 || bus.W_valM !== 64'd0 || bus.W_stat !== 3'd1 || bus.W_dstM !== 4'hF) begin
      fails++;
      $display("FAIL bubble got icode=%h valM=%h stat=%0d dstM=%h exp 1 0 1 F",
               bus.W_icode, bus.W_valM, bus.W_stat, bus.W_dstM);
    end
    bus.W_bubble = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive(4'h5, 3'd1, 64'h200, 64'h0, 4'h7, 4'h3);
    step();
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (bus.W_stat !== 3'd1 || bus.W_icode !== 4'h1 || bus.W_dstE !== 4'hF || bus.W_dstM !== 4'hF) begin
      fails++;
      $display("FAIL reset_mid got stat=%0d icode=%h dstE=%h dstM=%h exp 1 1 F F",
               bus.W_stat, bus.W_icode, bus.W_dstE, bus.W_dstM);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(4'h5, 3'd1, 64'h100, 64'h0, 4'h7, 4'h3);
    tests++;
    if (bus.m_valM !== 64'h1122334455667788) begin
      fails++;
      $display("FAIL reset_mem_kept got %h exp 1122334455667788", bus.m_valM);
    end
    step();
    tests++;
    if (bus.W_icode !== 4'h5 || bus.W_dstM !== 4'h3 || bus.W_valM !== 64'h1122334455667788) begin
      fails++;
      $display("FAIL reset_release got icode=%h dstM=%h valM=%h exp 5 3 1122334455667788",
               bus.W_icode, bus.W_dstM, bus.W_valM);
    end
  endtask

  task automatic test_align();
    drive(4'h4, 3'd1, 64'h300, 64'h0102030405060708, 4'hF, 4'hF);
    step();
    drive(4'h4, 3'd1, 64'h308, 64'h0, 4'hF, 4'hF);
    step();
    drive(4'h4, 3'd1, 64'h303, 64'hA5A5A5A5A5A5A5A5, 4'hF, 4'hF);
`ifdef MEM_ALIGN_CHECK_EN
    tests++;
    if (bus.m_stat !== 3'd3) begin
      fails++;
      $display("FAIL align_err got stat %0d exp 3", bus.m_stat);
    end
    step();
    drive(4'h5, 3'd1, 64'h300, 64'h0, 4'hF, 4'h1);
    tests++;
    if (bus.m_valM !== 64'h0102030405060708) begin
      fails++;
      $display("FAIL align_no_write got %h exp 0102030405060708", bus.m_valM);
    end
`else
    tests++;
    if (bus.m_stat !== 3'd1) begin
      fails++;
      $display("FAIL align_ok got stat %0d exp 1", bus.m_stat);
    end
    step();
    drive(4'h5, 3'd1, 64'h303, 64'h0, 4'hF, 4'h1);
    tests++;
    if (bus.m_valM !== 64'hA5A5A5A5A5A5A5A5) begin
      fails++;
      $display("FAIL align_readback got %h exp a5a5a5a5a5a5a5a5", bus.m_valM);
    end
    drive(4'h5, 3'd1, 64'h300, 64'h0, 4'hF, 4'h1);
    tests++;
    if (bus.m_valM !== 64'hA5A5A5A5A5060708) begin
      fails++;
      $display("FAIL align_neighbour got %h exp a5a5a5a5a5060708", bus.m_valM);
    end
`endif
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    rst          = 1'b1;
    bus.W_stall  = 1'b0;
    bus.W_bubble = 1'b0;
    drive(4'h1, 3'd1, 64'h0, 64'h0, 4'hF, 4'hF);
    test_reset();
    test_store_load();
    test_range();
    test_stall();
    test_stall_bubble();
    test_reset_mid();
    test_align();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the Y86-64 pipeline, placed directly downstream of the M pipeline register. Takes the registered M_* fields, performs the data-memory read or write the instruction requires, and produces the forwarding values m_valM/m_stat. Also holds the W pipeline register that feeds writeback, with stall and bubble control from the pipeline control unit.

## Interface
Parameters:
- MEM_BYTES, 1024: data memory size in bytes; valid addresses 0..MEM_BYTES-8 for an 8-byte access.
- ADDR_W, 64: address width; always the full 64-bit valE/valA.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- M_stat  input  3  status from M register.
- M_icode  input  4  instruction code.
- M_cnd  input  1  condition flag; carried but unused for memory.
- M_valE  input  64  ALU result / address.
- M_valA  input  64  store data / pop address.
- M_dstE, M_dstM  input  4  destination register IDs; 0xF = none.
- W_stall  input  1  hold W register and suppress memory writes.
- W_bubble  input  1  load nop bubble into W.
- m_valM  output  64  combinational read data, for forwarding.
- m_stat  output  3  combinational stage status, for forwarding/control.
- W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM  output  3/4/64/64/4/4  registered W fields.

## Operation
- Stat codes: AOK=1, HLT=2, ADR=3, INS=4. Icodes: rmmovq=4, mrmovq=5, call=8, ret=9, pushq=0xA, popq=0xB, nop=1.
- Address: M_valA for popq/ret, M_valE for rmmovq/mrmovq/pushq/call; others no access.
- Read: mrmovq, popq, ret. Write: rmmovq, pushq, call; write data = M_valA.
- Little-endian 8-byte access; byte at addr is bits [7:0].
- dmem_error = access && (addr > MEM_BYTES-8); unsigned 64-bit compare, so no address wrap-around.
- m_stat = ADR if dmem_error, else M_stat.
- m_valM = read data if read && !dmem_error, else 0.
- Write commits at posedge clk only if write && !dmem_error && M_stat==AOK && !W_stall.
- Memory contents are not affected by rst.
- W update priority at posedge: W_stall holds all W fields (highest); else W_bubble loads stat=AOK, icode=nop, valE=valM=0, dstE=dstM=0xF; else W <= {m_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM}.

## Timing
- rst asserted: W fields immediately take the bubble values; no memory write that cycle.
- rst deasserted mid-operation: the first posedge after release captures normally.
- Read path is combinational; m_valM is valid in the same cycle as M_*.
- Write is visible to a read of the same address on the next cycle.
- A same-cycle read and write are mutually exclusive by icode.
- Latency M -> W is one cycle.
- W_stall and W_bubble both high: stall wins.

## Configuration
- MEM_ALIGN_CHECK_EN defined: an access with addr[2:0] != 0 also sets dmem_error. It yields m_stat=ADR and suppresses the write.
- MEM_ALIGN_CHECK_EN undefined: unaligned accesses are legal and byte-exact.

## Structure
- Shared package y86_pkg: stat constants (STAT_AOK/HLT/ADR/INS), icode constants, REG_NONE=4'hF.
- Sub-module data_memory: byte array of MEM_BYTES entries, combinational 8-byte read, synchronous gated 8-byte write, and range/alignment error output.
- memory_stage itself holds address/control decode and the W register.

## Test plan
- rst pulse mid-run -> W_stat=1, W_icode=1, W_dstE=W_dstM=0xF asynchronously; memory retains prior data.
- rmmovq, valE=0x100, valA=0x1122334455667788, then mrmovq from 0x100 -> m_valM=0x1122334455667788; byte 0x100 reads 0x88 via valE=0x100 with 8-byte window.
- mrmovq, valE=MEM_BYTES-7 (1017) -> m_stat=3, m_valM=0, next-cycle W_stat=3; valE=0xFFFFFFFFFFFFFFF8 -> ADR, no wrap.
- pushq with W_stall=1 -> no write, W unchanged; repeat with W_stall=0 -> write commits.
- W_stall=W_bubble=1 -> W held; W_bubble only -> W_icode=1, W_valM=0.
- MEM_ALIGN_CHECK_EN on: rmmovq to 0x103 -> m_stat=3, memory unchanged. Off: same access succeeds and reads back.
